// File: rtl/tx_gearbox.sv
// 10GBASE-R TX gearbox: packs 66-bit blocks into a continuous 32-bit stream.
// Optional TX_GEARBOX_CHECK_EN adds a sticky invalid sync-header flag.
module tx_gearbox (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic [31:0] idata,
    input  logic [1:0]  iheader,
    output logic        header_phase,
    output logic        pause,
    output logic [31:0] odata
`ifdef TX_GEARBOX_CHECK_EN
    ,
    output logic        header_err
`endif
);

    localparam logic [5:0] SEQ_LAST = 6'd32;

    logic        clr;
    logic [5:0]  seq;
    logic        half;
    logic [65:0] buf_q;
    logic [6:0]  cnt;
    logic [65:0] acc;
    logic [6:0]  acc_len;
    logic [65:0] merged;

    assign clr          = reset || !init_done;
    assign pause        = (seq == SEQ_LAST);
    assign header_phase = !half;

    always_comb begin
        acc     = '0;
        acc_len = '0;
        if (!pause) begin
            if (!half) begin
                acc     = {32'd0, idata, iheader};
                acc_len = 7'd34;
            end else begin
                acc     = {34'd0, idata};
                acc_len = 7'd32;
            end
        end
        // Residual never exceeds 32 bits, so the merge fits in 66 bits
        merged = buf_q | (acc << cnt);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            seq   <= '0;
            half  <= 1'b0;
            buf_q <= '0;
            cnt   <= '0;
            odata <= '0;
        end else begin
            seq   <= pause ? 6'd0 : seq + 6'd1;
            half  <= pause ? half : !half;
            odata <= merged[31:0];
            buf_q <= merged >> 32;
            cnt   <= cnt + acc_len - 7'd32;
        end
    end

`ifdef TX_GEARBOX_CHECK_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            header_err <= 1'b0;
        end else if (!pause && !half &&
                     (iheader == 2'b00 || iheader == 2'b11)) begin
            header_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_gearbox.sv
// Directed + random stream bench for tx_gearbox against a serial bit-queue model.
// Exercises header checking when TX_GEARBOX_CHECK_EN is defined.
module tb_tx_gearbox;

    logic        clk;
    logic        reset;
    logic        init_done;
    logic [31:0] idata;
    logic [1:0]  iheader;
    logic        header_phase;
    logic        pause;
    logic [31:0] odata;
`ifdef TX_GEARBOX_CHECK_EN
    logic        header_err;
`endif

    tx_gearbox dut (
        .clk          (clk),
        .reset        (reset),
        .init_done    (init_done),
        .idata        (idata),
        .iheader      (iheader),
        .header_phase (header_phase),
        .pause        (pause),
        .odata        (odata)
`ifdef TX_GEARBOX_CHECK_EN
        ,
        .header_err   (header_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk;
    int npass;
    bit q[$];
    int mseq;
    bit mhalf;
    bit merr;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nchk++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge: check this cycle's outputs, then drive its inputs
    task automatic cycle(input logic [31:0] d, input logic [1:0] h);
        logic [31:0] e;
        bit          p;
        e = '0;
        p = (mseq == 32);
        check("pause", pause, p);
        check("header_phase", header_phase, !mhalf);
        if (q.size() >= 32)
            for (int i = 0; i < 32; i++) e[i] = q.pop_front();
        check("odata", odata, e);
`ifdef TX_GEARBOX_CHECK_EN
        check("header_err", header_err, merr);
`endif
        idata   = d;
        iheader = h;
        if (!p) begin
            if (!mhalf) begin
                q.push_back(h[0]);
                q.push_back(h[1]);
                if (h == 2'b00 || h == 2'b11) merr = 1'b1;
            end
            for (int i = 0; i < 32; i++) q.push_back(d[i]);
            mhalf = !mhalf;
        end
        mseq = p ? 0 : mseq + 1;
        @(negedge clk);
    endtask

    task automatic rnd_cycle();
        cycle($urandom, 2'($urandom_range(1, 2)));
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) rnd_cycle();
    endtask

    task automatic do_reset(input int n, input bit via_init);
        if (via_init) init_done = 1'b0;
        else reset = 1'b1;
        idata   = $urandom;
        iheader = 2'b11;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_odata", odata, 32'h0);
            check("rst_pause", pause, 1'b0);
            check("rst_hphase", header_phase, 1'b1);
`ifdef TX_GEARBOX_CHECK_EN
            check("rst_herr", header_err, 1'b0);
`endif
        end
        reset     = 1'b0;
        init_done = 1'b1;
        q.delete();
        mseq  = 0;
        mhalf = 1'b0;
        merr  = 1'b0;
    endtask

    logic [31:0] d15;
    logic [31:0] x16;

    initial begin
        nchk      = 0;
        npass     = 0;
        reset     = 1'b1;
        init_done = 1'b1;
        idata     = '0;
        iheader   = 2'b01;
        mseq      = 0;
        mhalf     = 1'b0;
        merr      = 1'b0;
        @(negedge clk);
        do_reset(3, 1'b0);

        // Bit order on block 0
        cycle(32'hFFFF_FFFF, 2'b01);
        check("bo_c1", odata, 32'hFFFF_FFFD);
        cycle(32'h0000_0000, 2'b10);
        check("bo_c2", odata, 32'h0000_0003);
        run_random(100);

        // Period boundary: 16 blocks, garbage on pause, then block 16
        do_reset(1, 1'b0);
        d15 = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                d15 = $urandom;
                cycle(d15, 2'b11);
            end else begin
                rnd_cycle();
            end
        end
        cycle(32'hDEAD_BEEF, 2'b00);
        check("period_last", odata, 64'(d15));
        x16 = $urandom;
        cycle(x16, 2'b10);
        check("blk16_hdr", odata[1:0], 2'b10);
        check("blk16_data", odata[31:2], 64'(x16[29:0]));

        // Long random stream: about 1000 blocks
        run_random(2070);

        // Reset mid-block at seq 17
        while (mseq != 17) rnd_cycle();
        do_reset(1, 1'b0);
        run_random(70);

        // init_done low behaves as reset
        run_random(13);
        do_reset(2, 1'b1);
        run_random(40);

`ifdef TX_GEARBOX_CHECK_EN
        do_reset(1, 1'b0);
        while (!mhalf || mseq == 32) rnd_cycle();
        cycle($urandom, 2'b11);
        while (mseq != 32) rnd_cycle();
        cycle($urandom, 2'b11);
        check("herr_clear", header_err, 1'b0);
        cycle($urandom, 2'b11);
        check("herr_set", header_err, 1'b1);
        run_random(6);
        check("herr_sticky", header_err, 1'b1);
        do_reset(1, 1'b0);
        run_random(10);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/tx_gearbox.md
# tx_gearbox

Transmit gearbox for the 10GBASE-R PCS, directly downstream of the 32-bit scrambler and the 2-bit sync-header path. It packs each 66-bit block (2-bit header plus 64 scrambled payload bits, delivered over two 32-bit cycles) into a continuous 32-bit stream for the transceiver. It owns the block-phase and pause schedule that throttle the encoder and scrambler, so 1056 input bits map exactly onto 33 output words.

## Interface
- No parameters. The data width is fixed at 32, the header width at 2.
- `clk` input, 1: PCS TX clock.
- `reset` input, 1: synchronous, active-high.
- `init_done` input, 1: while low, the block behaves as in reset.
- `idata` input, 32: scrambled payload half-block, LSB transmitted first.
- `iheader` input, 2: sync header; sampled only when `header_phase`=1 and `pause`=0; bit 0 transmitted first.
- `header_phase` output, 1: high on the cycle where upstream must present the first half of a block plus its header.
- `pause` output, 1: high on the cycle where upstream must hold. `idata` and `iheader` are ignored on that cycle.
- `odata` output, 32: gearboxed stream to the transceiver, LSB transmitted first; registered.
- `header_err` output, 1: sticky invalid-header flag. Present only with `TX_GEARBOX_CHECK_EN`.

## Operation
- `seq` is a 6-bit counter, 0..32. It increments every cycle and wraps from 32 to 0.
- `pause` = (`seq`==32), decoded from the registered `seq` (no input-to-output combinational path).
- `half` is a 1-bit block-phase register. It toggles on every non-paused cycle and holds on a paused cycle.
- `header_phase` = !`half`.
- Each 33-cycle period carries 32 accept cycles, which is 16 complete blocks. `pause` therefore always falls between blocks and never mid-block.
- Bit buffer `buf` is 66 bits wide; `cnt` (7 bits) is the number of valid bits, LSB-aligned.
- Accepted bits per cycle:
  - `header_phase` and not paused: 34 bits, `{idata, iheader}`.
  - Second half, not paused: 32 bits, `idata`.
  - Paused: 0 bits.
- Per cycle:
  - Merged = `buf` | (accepted << `cnt`).
  - `odata` <= merged[31:0].
  - `buf` <= merged >> 32.
  - `cnt` <= `cnt` + accepted − 32.
- Before output, `cnt` + accepted is always ≥ 32. Residual `cnt` is 2·k after the k-th block of a period (k=1..16) and returns to 0 after the pause cycle. The maximum merged occupancy is 66 bits.
- Reset, or `init_done`=0:
  - `seq`=0, `half`=0, `buf`=0, `cnt`=0, `odata`=0.
  - `header_phase`=1, `pause`=0.
- Reset asserted mid-block or mid-period discards all buffered bits. The next cycle after release is `seq`=0, `header_phase`=1.

## Timing
- Outputs after release: `header_phase` is 1 on the first cycle after reset is released; `pause` first asserts 32 cycles after release.
- Latency: input bits accepted in cycle N appear in `odata` from cycle N+1, strictly in order. The bit at position p in the transmitted serial sequence (0-based, counted from the first bit accepted after release) appears at `odata[p mod 32]` on cycle ⌊p/32⌋+1.
- Upstream contract:
  - The encoder and scrambler sample `pause`/`header_phase` in the same cycle they are driven.
  - The scrambler `pause` input connects directly to `pause`.
  - No valid/ready is provided; the schedule is fixed.
- Throughput: 32 output bits every cycle, with no idle output words once streaming.

## Configuration
- `TX_GEARBOX_CHECK_EN` defined:
  - Adds the `header_err` port.
  - `header_err` is set one cycle after an accepted `iheader` equal to 2'b00 or 2'b11, and stays high until reset or `init_done` low.
  - Reset value is 0.
- `TX_GEARBOX_CHECK_EN` undefined: the port and its logic are absent; the datapath is identical.

## Test plan
- Reset/outputs: hold `reset`=1 for 3 cycles, then release → during reset `odata`=0, `pause`=0, `header_phase`=1. After release, `pause` is high only on cycles 32, 65 and 98, and `header_phase` alternates 1,0 and holds across each pause.
- Bit order: feed block 0 with `iheader`=2'b01 and `idata` 32'hFFFFFFFF, 32'h00000000 → cycle 1 `odata`=32'hFFFFFFFD, cycle 2 `odata`=32'h00000003. The serial stream is checked against a 66-bit reference model over 1000 random blocks.
- Period boundary: stream 16 random blocks → `odata` on cycle 33 (the one after pause) holds the last 32 bits of block 15. Reference-model residual is 0, and block 16 header bits land at `odata[1:0]` on cycle 34.
- Pause inputs ignored: drive garbage `idata`/`iheader` on each `pause` cycle → output stream unchanged versus the reference.
- Mid-operation reset: assert `reset` at `seq`=17 (mid-block) for 1 cycle → next cycle `odata`=0, `header_phase`=1. The subsequent stream restarts cleanly, and `pause` falls 32 cycles after release.
- With `TX_GEARBOX_CHECK_EN`: a valid header stream keeps `header_err`=0. One `iheader`=2'b11 on a header phase sets `header_err` the next cycle and keeps it high until `reset`. A 2'b11 on a second-half or pause cycle does not set it.
